// File: rtl/click_pkg.sv
// click_pkg: shared types and limits for the click pattern decoder.
// Holds the FSM state enum, the event count width and legal ranges.
package click_pkg;

   // Width of the click count carried with each event.
   localparam int COUNT_W = 2;

   // Legal range for the burst-closing click count.
   localparam int MAX_CLICKS_MIN = 2;
   localparam int MAX_CLICKS_MAX = 3;

   // Shortest gap window that still leaves room for a count-up.
   localparam int GAP_CYCLES_MIN = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } click_state_t;

endpackage

// File: rtl/click_gap_timer.sv
// click_gap_timer: counts idle cycles between pulses of one burst.
// Ports: clk, rst (async high), clear, enable in; expired out.
module click_gap_timer #(
   parameter int GAP_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int GAP_W =
      (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'(GAP_CYCLES - 1);

   logic [GAP_W-1:0] gap_cnt;

   // Saturates at the last value rather than wrapping; the owner
   // clears it on the same edge the expiry is acted upon.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (clear) begin
         gap_cnt <= '0;
      end else if (enable && (gap_cnt != GAP_LAST)) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   assign expired = enable && (gap_cnt == GAP_LAST);

endmodule

// File: rtl/click_pattern_decoder.sv
// click_pattern_decoder: groups debounced pulses into bursts and
// classifies them as 1..MAX_CLICKS clicks.
// Ports: clk, rst (async high), pulse_in, evt_ready in;
// evt_valid, evt_count, drop_pulse, busy out.
module click_pattern_decoder
   import click_pkg::*;
#(
   parameter int GAP_CYCLES = 16,
   parameter int MAX_CLICKS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pulse_in,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [COUNT_W-1:0] evt_count,
   output logic               drop_pulse,
   output logic               busy
);

   if ((MAX_CLICKS < MAX_CLICKS_MIN) ||
       (MAX_CLICKS > MAX_CLICKS_MAX)) begin : g_bad_max
      $error("click_pattern_decoder: MAX_CLICKS out of range");
   end

   if (GAP_CYCLES < GAP_CYCLES_MIN) begin : g_bad_gap
      $error("click_pattern_decoder: GAP_CYCLES too small");
   end

   localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_CLICKS);

   click_state_t       state;
   click_state_t       state_nxt;
   logic [COUNT_W-1:0] click_cnt;
   logic [COUNT_W-1:0] click_nxt;
   logic [COUNT_W-1:0] click_inc;
   logic [COUNT_W-1:0] emit_cnt;
   logic               emit;
   logic               expired;
   logic               gap_clear;
   logic               gap_en;
   logic               out_free;

   assign click_inc = click_cnt + 1'b1;

   // Gap window restarts on every pulse, while idle, and on emit.
   assign gap_clear = (state == IDLE) || pulse_in || emit;
   assign gap_en    = (state == COLLECT) && !pulse_in;

   click_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap (
      .clk     (clk),
      .rst     (rst),
      .clear   (gap_clear),
      .enable  (gap_en),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pulse_in) begin
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (pulse_in) begin
               if (click_inc == MAX_C) begin
                  state_nxt = IDLE;
               end
            end else if (expired) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A pulse always wins over a timeout on the same edge: it is
   // counted and the gap window restarts.
   always_comb begin
      emit      = 1'b0;
      emit_cnt  = click_cnt;
      click_nxt = click_cnt;
      unique case (state)
         IDLE: begin
            if (pulse_in) begin
               click_nxt = COUNT_W'(1);
            end
         end
         COLLECT: begin
            if (pulse_in) begin
               if (click_inc == MAX_C) begin
                  emit      = 1'b1;
                  emit_cnt  = click_inc;
                  click_nxt = '0;
               end else begin
                  click_nxt = click_inc;
               end
            end else if (expired) begin
               emit      = 1'b1;
               emit_cnt  = click_cnt;
               click_nxt = '0;
            end
         end
         default: begin
            click_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         click_cnt <= '0;
      end else begin
         click_cnt <= click_nxt;
      end
   end

   // Slot is reusable when empty or being drained this edge.
   assign out_free = !evt_valid || evt_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid  <= 1'b0;
         evt_count  <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         if (emit) begin
            if (out_free) begin
               evt_valid <= 1'b1;
               evt_count <= emit_cnt;
            end else begin
               drop_pulse <= 1'b1;
            end
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

   assign busy = (state == COLLECT);

endmodule

// File: tb/tb_click_pattern_decoder.sv
// tb_click_pattern_decoder: directed self-checking bench for
// click_pattern_decoder with GAP_CYCLES=16, MAX_CLICKS=3.
module tb_click_pattern_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pulse_in = 1'b0;
   logic       evt_ready = 1'b1;
   logic       evt_valid;
   logic [1:0] evt_count;
   logic       drop_pulse;
   logic       busy;

   int checks = 0;
   int failures = 0;

   click_pattern_decoder #(
      .GAP_CYCLES (16),
      .MAX_CLICKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_count  (evt_count),
      .drop_pulse (drop_pulse),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [1:0] c, input logic d,
                          input logic b);
      chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
      chk({tag, ".count"}, 32'(evt_count), 32'(c));
      chk({tag, ".drop"}, 32'(drop_pulse), 32'(d));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   initial begin
      // Reset state
      idle(3);
      chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2);
      chk_out("post_reset", 1'b0, 2'd0, 1'b0, 1'b0);

      // Single click: timeout 16 edges after the pulse
      pulse();
      chk_out("s1_start", 1'b0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("s1_wait.valid", 32'(evt_valid), 32'd0);
         chk("s1_wait.busy", 32'(busy), 32'd1);
      end
      tick();
      chk_out("s1_emit", 1'b1, 2'd1, 1'b0, 1'b0);
      tick();
      chk_out("s1_xfer", 1'b0, 2'd1, 1'b0, 1'b0);

      // Double click: pulses 10 edges apart
      idle(2);
      pulse();
      idle(9);
      pulse();
      idle(15);
      chk_out("s2_wait", 1'b0, 2'd1, 1'b0, 1'b1);
      tick();
      chk_out("s2_emit", 1'b1, 2'd2, 1'b0, 1'b0);
      tick();
      chk("s2_xfer.valid", 32'(evt_valid), 32'd0);

      // Second pulse exactly on the timeout edge is still counted
      idle(2);
      pulse();
      idle(15);
      pulse();
      chk_out("s2b_late", 1'b0, 2'd2, 1'b0, 1'b1);
      idle(15);
      chk("s2b_wait.valid", 32'(evt_valid), 32'd0);
      tick();
      chk_out("s2b_emit", 1'b1, 2'd2, 1'b0, 1'b0);
      tick();

      // Triple click closes immediately; next edge starts a burst
      idle(2);
      pulse();
      tick();
      pulse();
      tick();
      pulse();
      chk_out("s3_emit", 1'b1, 2'd3, 1'b0, 1'b0);
      pulse();
      chk_out("s3_next", 1'b0, 2'd3, 1'b0, 1'b1);
      idle(15);
      chk("s3_wait.valid", 32'(evt_valid), 32'd0);
      tick();
      chk_out("s3_emit1", 1'b1, 2'd1, 1'b0, 1'b0);
      tick();
      chk("s3_xfer.valid", 32'(evt_valid), 32'd0);

      // Back-pressure: second event dropped, first held
      evt_ready = 1'b0;
      idle(2);
      pulse();
      idle(16);
      chk_out("s4_held", 1'b1, 2'd1, 1'b0, 1'b0);
      idle(2);
      pulse();
      pulse();
      idle(15);
      chk_out("s4_pre", 1'b1, 2'd1, 1'b0, 1'b1);
      tick();
      chk_out("s4_drop", 1'b1, 2'd1, 1'b1, 1'b0);
      tick();
      chk_out("s4_drop_end", 1'b1, 2'd1, 1'b0, 1'b0);
      evt_ready = 1'b1;
      tick();
      chk("s4_xfer.valid", 32'(evt_valid), 32'd0);
      tick();
      chk("s4_once.valid", 32'(evt_valid), 32'd0);

      // Accept and emit on the same edge: replacement, no drop
      evt_ready = 1'b0;
      pulse();
      idle(16);
      chk_out("s5_held", 1'b1, 2'd1, 1'b0, 1'b0);
      pulse();
      idle(2);
      pulse();
      idle(15);
      chk_out("s5_pre", 1'b1, 2'd1, 1'b0, 1'b1);
      evt_ready = 1'b1;
      tick();
      chk_out("s5_swap", 1'b1, 2'd2, 1'b0, 1'b0);
      tick();
      chk("s5_xfer.valid", 32'(evt_valid), 32'd0);

      // Asynchronous reset mid-burst with an event held
      evt_ready = 1'b0;
      pulse();
      idle(16);
      chk_out("s6_held", 1'b1, 2'd1, 1'b0, 1'b0);
      pulse();
      idle(2);
      pulse();
      idle(3);
      #2;
      rst = 1'b1;
      #1;
      chk_out("s6_rst", 1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      evt_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("s6_quiet.valid", 32'(evt_valid), 32'd0);
      end
      chk("s6_quiet.busy", 32'(busy), 32'd0);
      pulse();
      pulse();
      chk_out("s6_restart", 1'b0, 2'd0, 1'b0, 1'b1);
      idle(15);
      tick();
      chk_out("s6_emit", 1'b1, 2'd2, 1'b0, 1'b0);
      tick();
      chk("s6_xfer.valid", 32'(evt_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/click_pattern_decoder.md
Name: click_pattern_decoder

Overview:
- Sits directly downstream of the input debouncer. Consumes its single-cycle clean pulse stream.
- Groups pulses that arrive close together into one burst and classifies the burst as a single, double or triple click.
- Hands each classified event to control logic through a one-entry valid/ready output register.
- Events that find the output register still occupied are dropped, and the drop is flagged.

Parameters:
- GAP_CYCLES, 16: maximum number of idle cycles allowed between pulses of one burst. Must be at least 2.
- MAX_CLICKS, 3: click count at which a burst closes immediately. Legal range 2..3.
- COUNT_W, 2: width of evt_count. Fixed at 2 for MAX_CLICKS ≤ 3.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- pulse_in, input, 1: clean single-cycle pulse from the debouncer. Sampled on every edge.
- evt_valid, output, 1: a classified event is held in the output register.
- evt_ready, input, 1: consumer accepts the event. A transfer happens on an edge where evt_valid && evt_ready.
- evt_count, output, COUNT_W: number of clicks in the held event (1..MAX_CLICKS). Stable while evt_valid is high.
- drop_pulse, output, 1: one-cycle flag. A burst completed while the output register was full and not being drained.
- busy, output, 1: high while a burst is being collected (state COLLECT).

Behaviour:
- Reset (asynchronous assert, released synchronously by the system):
  - State IDLE; click_cnt = 0; gap_cnt = 0.
  - evt_valid = 0, evt_count = 0, drop_pulse = 0, busy = 0.
  - A burst in progress when reset asserts is discarded; no event is produced.
- States: IDLE, COLLECT.
- IDLE:
  - pulse_in=1 at an edge → COLLECT, click_cnt = 1, gap_cnt = 0.
  - pulse_in=0 → stay in IDLE.
- COLLECT, pulse_in=1 at an edge:
  - The pulse is always counted, including on the timeout edge.
  - click_cnt+1 < MAX_CLICKS → click_cnt increments, gap_cnt = 0, stay in COLLECT.
  - click_cnt+1 == MAX_CLICKS → emit count MAX_CLICKS, go to IDLE. evt_valid is high in the cycle after the MAX-th pulse is sampled.
- COLLECT, pulse_in=0 at an edge:
  - gap_cnt < GAP_CYCLES-1 → gap_cnt increments.
  - gap_cnt == GAP_CYCLES-1 → timeout: emit click_cnt, go to IDLE.
  - Timing: with the final pulse sampled at edge t0 and no pulse on edges t0+1..t0+GAP_CYCLES, evt_valid rises after edge t0+GAP_CYCLES.
- Pulse timing:
  - A pulse sampled in IDLE on the edge right after an emit starts a new burst. There is no dead time.
  - Pulses wider than one cycle count once per sampled high cycle. The upstream debouncer guarantees single-cycle pulses; this block does not re-check.
- Emit, at the emitting edge:
  - The output register is free if evt_valid==0 or (evt_valid && evt_ready). If free: load evt_count and set evt_valid=1.
  - Accept and emit on the same edge: the new event replaces the old one and evt_valid stays 1.
  - Register not free: the burst is discarded, drop_pulse=1 for exactly one cycle, and the held event is unchanged.
- Handshake:
  - Once high, evt_valid and evt_count hold until a transfer edge.
  - Transfer with no simultaneous emit → evt_valid = 0 and evt_count holds its last value.
  - evt_ready is ignored while evt_valid is low.
- busy = (state == COLLECT), registered.
- Widths and counters:
  - gap_cnt is $clog2(GAP_CYCLES) bits wide.
  - click_cnt is COUNT_W bits and never exceeds MAX_CLICKS.
  - No counter wraps; every counter resets on emit.

Decomposition:
- Shared package click_pkg holds:
  - the state enum {IDLE, COLLECT};
  - COUNT_W;
  - localparams for the legal MAX_CLICKS range.
- Sub-module click_gap_timer holds the gap counter.
  - Inputs: clear, enable.
  - Output: expired (gap_cnt == GAP_CYCLES-1 && enable).
- The FSM, click counter and output register stay in the top module.

Test Plan:
- Bench parameters GAP_CYCLES=16, MAX_CLICKS=3, evt_ready held at 1 unless stated.
- Single pulse at edge 10, nothing after → evt_valid rises after edge 26 with evt_count=1. One-cycle transfer; busy high over edges 10..25.
- Pulses at edges 10 and 20 → evt_count=2, evt_valid rises after edge 36. Pulses at 10 and 26 also give count 2, since a pulse on the timeout edge is counted.
- Pulses at edges 10, 12, 14 → evt_count=3, evt_valid rises after edge 14 with no gap wait. A pulse at edge 15 starts a new burst: count 1 emitted after edge 31.
- evt_ready=0, two separate single bursts → first event held with count 1. Second completion gives drop_pulse for one cycle and the held count is unchanged. Raising evt_ready gives one transfer.
- evt_ready=0 with an event held, evt_ready raised exactly on the emit edge of a count-2 burst → evt_valid stays 1, evt_count becomes 2, no drop_pulse.
- rst asserted asynchronously mid-burst (after 2 pulses) → all outputs 0 immediately. No event after release; the next pulse starts from click_cnt=1.
